rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 100 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin arbiter for three write-back requesters onto one register-file write port
// Registered write port with same-cycle forwarding compare against two read addresses.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req_valid,
  input  logic [3*ADDR_WIDTH-1:0] req_reg,
  input  logic [3*DATA_WIDTH-1:0] req_data,
  output logic [2:0]              req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr1,
  input  logic [ADDR_WIDTH-1:0]   rd_addr2,
  output logic                    RegWrite,
  output logic [ADDR_WIDTH-1:0]   Write_register,
  output logic [DATA_WIDTH-1:0]   Write_data,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [DATA_WIDTH-1:0]   fwd_data
);

  logic [1:0]            rr_ptr;
  logic [1:0]            rr_next;
  logic [1:0]            gidx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;

  // State register: pointer plus the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= 2'd0;
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else begin
      rr_ptr   <= rr_next;
      RegWrite <= grant_any && (sel_reg != '0);
      if (grant_any) begin
        Write_register <= sel_reg;
        Write_data     <= sel_data;
      end
    end
  end

  // Next-state: pointer moves just past the winner, holds when idle.
  always_comb begin
    rr_next = rr_ptr;
    if (grant_any) begin
      rr_next = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end
  end

  // Output: rotating priority search starting at rr_ptr; pointer value 3 is treated as 0.
  always_comb begin
    gidx      = 2'd0;
    grant_any = 1'b0;
    case (rr_ptr)
      2'd1: begin
        if (req_valid[1])      begin gidx = 2'd1; grant_any = 1'b1; end
        else if (req_valid[2]) begin gidx = 2'd2; grant_any = 1'b1; end
        else if (req_valid[0]) begin gidx = 2'd0; grant_any = 1'b1; end
      end
      2'd2: begin
        if (req_valid[2])      begin gidx = 2'd2; grant_any = 1'b1; end
        else if (req_valid[0]) begin gidx = 2'd0; grant_any = 1'b1; end
        else if (req_valid[1]) begin gidx = 2'd1; grant_any = 1'b1; end
      end
      default: begin
        if (req_valid[0])      begin gidx = 2'd0; grant_any = 1'b1; end
        else if (req_valid[1]) begin gidx = 2'd1; grant_any = 1'b1; end
        else if (req_valid[2]) begin gidx = 2'd2; grant_any = 1'b1; end
      end
    endcase
    if (reset) begin
      grant_any = 1'b0;
    end
    req_ready = grant_any ? (3'b001 << gidx) : 3'b000;
    case (gidx)
      2'd1: begin
        sel_reg  = req_reg[ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_reg  = req_reg[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        sel_reg  = req_reg[0 +: ADDR_WIDTH];
        sel_data = req_data[0 +: DATA_WIDTH];
      end
    endcase
  end

  assign fwd_hit1 = !reset && RegWrite && (Write_register == rd_addr1) && (rd_addr1 != '0);
  assign fwd_hit2 = !reset && RegWrite && (Write_register == rd_addr2) && (rd_addr2 != '0);
  assign fwd_data = Write_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
// Directed scenarios plus a randomized run against a queue-free round-robin reference model.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req_valid;
  logic [3*AW-1:0] req_reg;
  logic [3*DW-1:0] req_data;
  logic [2:0]    req_ready;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          RegWrite;
  logic [AW-1:0] Write_register;
  logic [DW-1:0] Write_data;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data;

  int n_vec = 0;
  int n_err = 0;

  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_reg(req_reg),
    .req_data(req_data), .req_ready(req_ready), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .RegWrite(RegWrite), .Write_register(Write_register),
    .Write_data(Write_data), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data(fwd_data)
  );

  // Winner is the first valid requester found walking from the pointer, modulo 3.
  function automatic int model_grant();
    if (reset) return -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_step();
    int g;
    g = model_grant();
    if (reset) begin
      m_ptr = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
    end else if (g >= 0) begin
      m_reg  = req_reg[g*AW +: AW];
      m_data = req_data[g*DW +: DW];
      m_we   = (m_reg != '0);
      m_ptr  = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_reg[i*AW +: AW] = r;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 3'b000;
    @(posedge clk);
    model_step();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 3'b111;
    req_reg = '1;
    req_data = {$urandom, $urandom, $urandom};
    rd_addr1 = 5'd31;
    rd_addr2 = 5'd31;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    n_vec++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin n_err++; $display("FAIL reset_fwd: got %b%b expected 00", fwd_hit1, fwd_hit2); end
    @(posedge clk);
    model_step();
    #1;
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
    n_vec++; if (Write_register !== '0) begin n_err++; $display("FAIL reset_wreg: got %0d expected 0", Write_register); end
    n_vec++; if (Write_data !== '0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", Write_data); end
    reset = 1'b0;
    req_valid = 3'b000;
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b010;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b expected 010", req_ready); end
    @(posedge clk); model_step(); #1;
    req_valid = 3'b000;
    n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL single_regwrite: got %b expected 1", RegWrite); end
    n_vec++; if (Write_register !== 5'd7) begin n_err++; $display("FAIL single_wreg: got %0d expected 7", Write_register); end
    n_vec++; if (Write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wdata: got %h expected deadbeef", Write_data); end
    @(posedge clk); model_step(); #1;
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL idle_regwrite: got %b expected 0", RegWrite); end
    n_vec++; if (Write_register !== 5'd7 || Write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_hold: got %0d/%h expected 7/deadbeef", Write_register, Write_data); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] er [3];
    logic [DW-1:0] ed [3];
    int g;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      er[i] = AW'($urandom_range(1, 31)); ed[i] = $urandom; set_req(i, er[i], ed[i]);
    end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      @(negedge clk);
      n_vec++; if (req_ready !== 3'(1 << g)) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready, 3'(1 << g)); end
      @(posedge clk); model_step(); #1;
      n_vec++; if (RegWrite !== 1'b1 || Write_register !== er[g] || Write_data !== ed[g])
        begin n_err++; $display("FAIL b2b_write[%0d]: got %b/%0d/%h expected 1/%0d/%h", k, RegWrite, Write_register, Write_data, er[g], ed[g]); end
      er[g] = AW'($urandom_range(1, 31)); ed[g] = $urandom; set_req(g, er[g], ed[g]);
    end
    req_valid = 3'b000;
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_req(0, 5'd0, 32'h12345678);
    req_valid = 3'b001;
    rd_addr1 = 5'd0;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL zero_ready: got %b expected 001", req_ready); end
    @(posedge clk); model_step(); #1;
    req_valid = 3'b000;
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL zero_regwrite: got %b expected 0", RegWrite); end
    n_vec++; if (fwd_hit1 !== 1'b0) begin n_err++; $display("FAIL zero_fwd: got %b expected 0", fwd_hit1); end
  endtask

  task automatic test_forward();
    do_reset();
    set_req(0, 5'd5, 32'hA5A5A5A5);
    req_valid = 3'b001;
    @(posedge clk); model_step(); #1;
    req_valid = 3'b000;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd6;
    #1;
    n_vec++; if (fwd_hit1 !== 1'b1 || fwd_hit2 !== 1'b0) begin n_err++; $display("FAIL fwd_hits: got %b%b expected 10", fwd_hit1, fwd_hit2); end
    n_vec++; if (fwd_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL fwd_data: got %h expected a5a5a5a5", fwd_data); end
    rd_addr2 = 5'd5;
    #1;
    n_vec++; if (fwd_hit2 !== 1'b1) begin n_err++; $display("FAIL fwd_hit2_comb: got %b expected 1", fwd_hit2); end
  endtask

  task automatic test_same_dest();
    do_reset();
    set_req(0, 5'd9, 32'h11111111);
    set_req(1, 5'd9, 32'h22222222);
    req_valid = 3'b011;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL same_first_ready: got %b expected 001", req_ready); end
    @(posedge clk); model_step(); #1;
    req_valid = 3'b010;
    n_vec++; if (RegWrite !== 1'b1 || Write_register !== 5'd9 || Write_data !== 32'h11111111)
      begin n_err++; $display("FAIL same_first_write: got %b/%0d/%h expected 1/9/11111111", RegWrite, Write_register, Write_data); end
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL same_second_ready: got %b expected 010", req_ready); end
    @(posedge clk); model_step(); #1;
    req_valid = 3'b000;
    n_vec++; if (RegWrite !== 1'b1 || Write_register !== 5'd9 || Write_data !== 32'h22222222)
      begin n_err++; $display("FAIL same_second_write: got %b/%0d/%h expected 1/9/22222222", RegWrite, Write_register, Write_data); end
  endtask

  task automatic test_reset_handshake();
    do_reset();
    set_req(0, 5'd3, 32'hCAFEF00D);
    req_valid = 3'b001;
    @(posedge clk); model_step(); #1;
    set_req(1, 5'd4, 32'h0BADF00D);
    set_req(2, 5'd6, 32'h600DF00D);
    req_valid = 3'b110;
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rsths_ready: got %b expected 000", req_ready); end
    @(posedge clk); model_step(); #1;
    reset = 1'b0;
    n_vec++; if (RegWrite !== 1'b0 || Write_register !== '0 || Write_data !== '0)
      begin n_err++; $display("FAIL rsths_write: got %b/%0d/%h expected 0/0/0", RegWrite, Write_register, Write_data); end
    req_valid = 3'b111;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rsths_next_grant: got %b expected 001", req_ready); end
    @(posedge clk); model_step(); #1;
    req_valid = 3'b000;
  endtask

  task automatic test_random();
    logic [2:0] pend;
    int lost [3];
    int g;
    logic [2:0] exp_ready;
    do_reset();
    pend = 3'b000;
    for (int i = 0; i < 3; i++) lost[i] = 0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1; lost[i] = 0;
          set_req(i, ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31)), $urandom);
        end
      end
      req_valid = pend;
      rd_addr1 = ($urandom_range(0, 1) == 1) ? m_reg : AW'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 1) == 1) ? m_reg : AW'($urandom_range(0, 31));
      @(negedge clk);
      g = model_grant();
      exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, req_ready, exp_ready); end
      n_vec++; if (fwd_hit1 !== (!reset && m_we && m_reg == rd_addr1 && rd_addr1 != '0))
        begin n_err++; $display("FAIL rnd_fwd1[%0d]: got %b", c, fwd_hit1); end
      n_vec++; if (fwd_hit2 !== (!reset && m_we && m_reg == rd_addr2 && rd_addr2 != '0))
        begin n_err++; $display("FAIL rnd_fwd2[%0d]: got %b", c, fwd_hit2); end
      n_vec++; if (fwd_data !== m_data) begin n_err++; $display("FAIL rnd_fwd_data[%0d]: got %h expected %h", c, fwd_data, m_data); end
      @(posedge clk);
      model_step();
      if (reset) begin
        pend = 3'b000;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (pend[i]) begin
            if (i == g) pend[i] = 1'b0;
            else begin
              lost[i]++;
              n_vec++; if (lost[i] > 2) begin n_err++; $display("FAIL rnd_fair[%0d] req %0d: waited %0d cycles expected <=2", c, i, lost[i]); end
            end
          end
        end
      end
      #1;
      n_vec++; if (RegWrite !== m_we || Write_register !== m_reg || Write_data !== m_data)
        begin n_err++; $display("FAIL rnd_write[%0d]: got %b/%0d/%h expected %b/%0d/%h", c, RegWrite, Write_register, Write_data, m_we, m_reg, m_data); end
    end
    reset = 1'b0;
    req_valid = 3'b000;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 3'b000;
    req_reg = '0;
    req_data = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    m_ptr = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_reg_zero();
    test_forward();
    test_same_dest();
    test_reset_handshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
